// File: rtl/lu_response_checker.sv
// lu_response_checker: handshakes test vectors in, drives them to the AND/NAND
// logic unit, waits a programmable settle time, then checks both unit outputs
// against the expected function and keeps saturating pass/fail statistics.
module lu_response_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             vec_a,
    input  logic             vec_b,
    input  logic             vec_sel,
    output logic             drv_a,
    output logic             drv_b,
    output logic             drv_sel,
    input  logic             dut_out1,
    input  logic             dut_out2,
    input  logic             stat_clr,
    output logic             res_valid,
    output logic             res_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             any_fail,
    output logic [2:0]       first_fail_vec,
    output logic [1:0]       first_fail_got
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    // The settle counter only ever holds values 0..SETTLE-1.
    localparam int unsigned      SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nx;
    logic [SC_W-1:0]   settle_cnt;
    logic              handshake;
    logic              sample;
    logic              exp_val;
    logic              vec_pass;

    logic [CNT_W-1:0]  pass_nx;
    logic [CNT_W-1:0]  fail_nx;
    logic              any_fail_nx;
    logic [2:0]        ffv_nx;
    logic [1:0]        ffg_nx;

    assign vec_ready = (state == ST_IDLE) & ~reset;
    assign handshake = vec_valid & vec_ready;
    assign sample    = (state == ST_SAMPLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: accept in IDLE, count down in SETTLE, check once in SAMPLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nx = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Settle counter: loaded on accept, decremented while settling.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (handshake) begin
            settle_cnt <= SC_LOAD;
        end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SC_W'(1);
        end
    end

    // Drive registers: hold the last accepted vector until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            drv_a   <= 1'b0;
            drv_b   <= 1'b0;
            drv_sel <= 1'b0;
        end else if (handshake) begin
            drv_a   <= vec_a;
            drv_b   <= vec_b;
            drv_sel <= vec_sel;
        end
    end

    // Expected unit output for the vector currently driven, and the verdict.
    always_comb begin
        exp_val  = drv_sel ? ~(drv_a & drv_b) : (drv_a & drv_b);
        vec_pass = (dut_out1 == exp_val) && (dut_out2 == exp_val);
    end

    // Statistics update: stat_clr is applied first, then the sampled result on top.
    always_comb begin
        pass_nx     = stat_clr ? '0 : pass_cnt;
        fail_nx     = stat_clr ? '0 : fail_cnt;
        any_fail_nx = stat_clr ? 1'b0 : any_fail;
        ffv_nx      = stat_clr ? '0 : first_fail_vec;
        ffg_nx      = stat_clr ? '0 : first_fail_got;
        if (sample) begin
            if (vec_pass) begin
                if (pass_nx != CNT_MAX) begin
                    pass_nx = pass_nx + CNT_W'(1);
                end
            end else begin
                if (fail_nx != CNT_MAX) begin
                    fail_nx = fail_nx + CNT_W'(1);
                end
                if (!any_fail_nx) begin
                    any_fail_nx = 1'b1;
                    ffv_nx      = {drv_sel, drv_a, drv_b};
                    ffg_nx      = {dut_out1, dut_out2};
                end
            end
        end
    end

    // Result strobe and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid      <= 1'b0;
            res_pass       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            any_fail       <= 1'b0;
            first_fail_vec <= '0;
            first_fail_got <= '0;
        end else begin
            res_valid      <= sample;
            if (sample) begin
                res_pass <= vec_pass;
            end
            pass_cnt       <= pass_nx;
            fail_cnt       <= fail_nx;
            any_fail       <= any_fail_nx;
            first_fail_vec <= ffv_nx;
            first_fail_got <= ffg_nx;
        end
    end

endmodule

// File: tb/tb_lu_response_checker.sv
// Bench for lu_response_checker: u0 uses SETTLE=2/CNT_W=16, u1 uses
// SETTLE=1/CNT_W=2. Each has a behavioural AND/NAND unit with an out2 fault switch.
module tb_lu_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic vv [2];
    logic vr [2];
    logic va [2];
    logic vb [2];
    logic vs [2];
    logic da [2];
    logic db [2];
    logic ds [2];
    logic o1 [2];
    logic o2 [2];
    logic sc [2];
    logic rv [2];
    logic rp [2];
    logic af [2];
    logic [2:0] ffv [2];
    logic [1:0] ffg [2];
    logic fault [2];
    logic [15:0] pc0, fc0;
    logic [1:0]  pc1, fc1;

    int checks = 0;
    int failures = 0;

    lu_response_checker #(.SETTLE(2), .CNT_W(16)) u0 (
        .clk(clk), .reset(rst),
        .vec_valid(vv[0]), .vec_ready(vr[0]),
        .vec_a(va[0]), .vec_b(vb[0]), .vec_sel(vs[0]),
        .drv_a(da[0]), .drv_b(db[0]), .drv_sel(ds[0]),
        .dut_out1(o1[0]), .dut_out2(o2[0]),
        .stat_clr(sc[0]),
        .res_valid(rv[0]), .res_pass(rp[0]),
        .pass_cnt(pc0), .fail_cnt(fc0),
        .any_fail(af[0]), .first_fail_vec(ffv[0]), .first_fail_got(ffg[0])
    );

    lu_response_checker #(.SETTLE(1), .CNT_W(2)) u1 (
        .clk(clk), .reset(rst),
        .vec_valid(vv[1]), .vec_ready(vr[1]),
        .vec_a(va[1]), .vec_b(vb[1]), .vec_sel(vs[1]),
        .drv_a(da[1]), .drv_b(db[1]), .drv_sel(ds[1]),
        .dut_out1(o1[1]), .dut_out2(o2[1]),
        .stat_clr(sc[1]),
        .res_valid(rv[1]), .res_pass(rp[1]),
        .pass_cnt(pc1), .fail_cnt(fc1),
        .any_fail(af[1]), .first_fail_vec(ffv[1]), .first_fail_got(ffg[1])
    );

    // Behavioural logic unit driven by each checker; fault forces out2 low.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            o1[i] = ds[i] ? ~(da[i] & db[i]) : (da[i] & db[i]);
            o2[i] = fault[i] ? 1'b0 : o1[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Offer one vector, check drv_* one cycle after accept, wait for res_valid.
    // lat = number of negedges after the accept edge at which res_valid is seen.
    task automatic run_vec(input int i, input logic s, input logic a, input logic b,
                           input int clr_k, output int lat, output logic pass, output time hs);
        int n = 0;
        while (!vr[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, vr[i]}, 32'd1);
        vv[i] = 1'b1; vs[i] = s; va[i] = a; vb[i] = b;
        @(posedge clk);
        hs = $time;
        #1 vv[i] = 1'b0;
        lat = -1;
        pass = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sc[i] = (k == clr_k);
            if (k == 1) chk("drv", {29'd0, ds[i], da[i], db[i]}, {29'd0, s, a, b});
            if (rv[i]) begin
                lat = k;
                pass = rp[i];
                break;
            end
        end
        sc[i] = 1'b0;
    endtask

    typedef struct {
        logic s;
        logic a;
        logic b;
        logic flt;
        logic exp_pass;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lat;
        logic pass;
        time hs, prev_hs;
        logic bad;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 2; i++) begin
            vv[i] = 0; va[i] = 0; vb[i] = 0; vs[i] = 0; sc[i] = 0; fault[i] = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, vr[0]}, 32'd1);
        chk("rst_res_valid", {31'd0, rv[0]}, 32'd0);
        chk("rst_pass_cnt", {16'd0, pc0}, 32'd0);
        chk("rst_drv", {29'd0, ds[0], da[0], db[0]}, 32'd0);

        // Single vector a=1 b=0 sel=0
        run_vec(0, 1'b0, 1'b1, 1'b0, 0, lat, pass, hs);
        chk("v1_latency", lat, 32'd4);
        chk("v1_pass", {31'd0, pass}, 32'd1);
        chk("v1_pass_cnt", {16'd0, pc0}, 32'd1);
        chk("v1_fail_cnt", {16'd0, fc0}, 32'd0);

        // Clear, then stream the table back-to-back
        sc[0] = 1'b1;
        @(negedge clk);
        sc[0] = 1'b0;
        chk("clr_pass_cnt", {16'd0, pc0}, 32'd0);
        prev_hs = 0;
        for (int i = 0; i < 10; i++) begin
            fault[0] = tbl[i].flt;
            run_vec(0, tbl[i].s, tbl[i].a, tbl[i].b, 0, lat, pass, hs);
            chk($sformatf("tbl%0d_latency", i), lat, 32'd4);
            chk($sformatf("tbl%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].exp_pass});
            if (i > 0) chk($sformatf("tbl%0d_spacing", i), 32'(hs - prev_hs), 32'd40);
            prev_hs = hs;
            if (i == 7) begin
                chk("stream_pass_cnt", {16'd0, pc0}, 32'd8);
                chk("stream_fail_cnt", {16'd0, fc0}, 32'd0);
                chk("stream_any_fail", {31'd0, af[0]}, 32'd0);
            end
        end
        chk("fault_fail_cnt", {16'd0, fc0}, 32'd2);
        chk("fault_any_fail", {31'd0, af[0]}, 32'd1);
        chk("fault_ff_vec", {29'd0, ffv[0]}, 32'b110);
        chk("fault_ff_got", {30'd0, ffg[0]}, 32'b10);
        fault[0] = 1'b0;

        // Saturation with CNT_W=2, SETTLE=1
        for (int i = 0; i < 5; i++) begin
            run_vec(1, i[0], i[1], 1'b0, 0, lat, pass, hs);
            chk($sformatf("sat%0d_latency", i), lat, 32'd3);
            chk($sformatf("sat%0d_pass_cnt", i), {30'd0, pc1}, (i < 2) ? 32'(i + 1) : 32'd3);
        end
        // stat_clr coincident with sample of a failing vector
        fault[1] = 1'b1;
        run_vec(1, 1'b0, 1'b1, 1'b1, 2, lat, pass, hs);
        chk("clrsamp_latency", lat, 32'd3);
        chk("clrsamp_pass", {31'd0, pass}, 32'd0);
        chk("clrsamp_pass_cnt", {30'd0, pc1}, 32'd0);
        chk("clrsamp_fail_cnt", {30'd0, fc1}, 32'd1);
        chk("clrsamp_any_fail", {31'd0, af[1]}, 32'd1);
        chk("clrsamp_ff_vec", {29'd0, ffv[1]}, 32'b011);
        chk("clrsamp_ff_got", {30'd0, ffg[1]}, 32'b10);
        fault[1] = 1'b0;

        // Reset for one cycle during SETTLE
        @(negedge clk);
        vv[0] = 1'b1; vs[0] = 1'b1; va[0] = 1'b1; vb[0] = 1'b1;
        @(posedge clk);
        #1 vv[0] = 1'b0;
        @(negedge clk);
        chk("abort_drv_loaded", {29'd0, ds[0], da[0], db[0]}, 32'b111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, vr[0]}, 32'd1);
        chk("abort_drv", {29'd0, ds[0], da[0], db[0]}, 32'd0);
        chk("abort_cnts", {pc0, fc0}, 32'd0);
        chk("abort_any_fail", {31'd0, af[0]}, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rv[0]) bad = 1'b1;
        end
        chk("abort_no_res_valid", {31'd0, bad}, 32'd0);

        // vec_valid held high while busy: no second accept until IDLE
        vv[0] = 1'b1; vs[0] = 1'b0; va[0] = 1'b0; vb[0] = 1'b1;
        @(posedge clk);
        #1 va[0] = 1'b1;
        bad = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (vr[0] || {ds[0], da[0], db[0]} != 3'b001) bad = 1'b1;
        end
        chk("hold_no_accept", {31'd0, bad}, 32'd0);
        @(negedge clk);
        chk("hold_res_valid", {31'd0, rv[0]}, 32'd1);
        chk("hold_ready", {31'd0, vr[0]}, 32'd1);
        chk("hold_res_pass", {31'd0, rp[0]}, 32'd1);
        @(posedge clk);
        #1 vv[0] = 1'b0;
        @(negedge clk);
        chk("hold_strobe_width", {31'd0, rv[0]}, 32'd0);
        chk("hold_second_drv", {29'd0, ds[0], da[0], db[0]}, 32'b011);
        lat = -1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (rv[0]) begin
                lat = k;
                break;
            end
        end
        chk("hold_second_latency", lat, 32'd4);
        chk("hold_pass_cnt", {16'd0, pc0}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lu_response_checker.md
# lu_response_checker

Self-checking response monitor for the selectable AND/NAND logic unit (inputs a, b, select; outputs out1, out2). It accepts test vectors over a valid/ready handshake and drives them onto the unit's inputs. After a programmable settle time it samples both unit outputs and compares them against the expected function. It reports a per-vector pass/fail and keeps running statistics, which moves checking out of simulation-only benches and into synthesizable logic.

## Interface
Parameters:
- SETTLE, 2, cycles between driving a vector and sampling the unit outputs; legal range ≥1
- CNT_W, 16, width of pass/fail counters

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- vec_valid  in  1  vector offered
- vec_ready  out  1  checker can accept a vector
- vec_a, vec_b, vec_sel  in  1 each  offered vector
- drv_a, drv_b, drv_sel  out  1 each  registered drive to the unit's a, b, select
- dut_out1, dut_out2  in  1 each  unit outputs
- stat_clr  in  1  one-cycle pulse; clears statistics
- res_valid  out  1  one-cycle result strobe
- res_pass  out  1  result of the last checked vector; valid while res_valid=1
- pass_cnt, fail_cnt  out  CNT_W  saturating counts
- any_fail  out  1  sticky; set on first mismatch
- first_fail_vec  out  3  {sel,a,b} of first mismatching vector
- first_fail_got  out  2  {out1,out2} observed at first mismatch

## Operation
- Expected value: exp = sel ? ~(a&b) : (a&b). Both out1 and out2 must equal exp for a pass. Any other combination is a fail.
- FSM states:
  - IDLE: vec_ready=1.
    - Handshake (vec_valid&vec_ready) → SETTLE. On that same edge: load drv_* from vec_*, load settle counter with SETTLE-1.
  - SETTLE: counter decrements each cycle. When it reaches 0 → SAMPLE.
  - SAMPLE: compare dut_out* against exp, computed from drv_*.
    - Set res_pass.
    - Increment pass_cnt or fail_cnt.
    - On fail with any_fail=0, also set any_fail and capture first_fail_vec/got.
    - → IDLE.
- vec_ready = (state==IDLE) & ~reset. vec_valid while busy is ignored; no buffering.
- drv_* hold the last vector in IDLE; they change only on handshake.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- The first_fail_* fields are never overwritten by later failures until stat_clr or reset.
- stat_clr clears pass_cnt, fail_cnt, any_fail and first_fail_*. It does not affect the FSM or drv_*.
- stat_clr on the same edge as a SAMPLE: the clear applies first, then the current result is recorded.
  - Example: a pass gives pass_cnt=1, fail_cnt=0.
  - A fail gives fail_cnt=1 and captures first_fail_* for that vector.
- Reset, at any state including mid-SETTLE:
  - FSM → IDLE; no res_valid is emitted for the aborted vector.
  - All outputs are 0, except vec_ready, which is 1 from the first cycle with reset low.

## Timing
- Handshake at edge E0. drv_* are valid after E0.
- dut_out* are sampled at edge E(SETTLE+1). res_valid, res_pass and the updated counters are visible in the cycle after that edge.
- res_valid is high exactly 1 cycle. vec_ready is high in that same cycle, so back-to-back vectors are possible.
- Throughput: one vector per SETTLE+2 cycles with vec_valid held high.
- The unit is combinational; any SETTLE ≥1 samples settled outputs.

## Test plan
- Reset, then vector a=1,b=0,sel=0 against a correct unit model, SETTLE=2 → drv_*=1/0/0 one cycle after handshake; res_valid 4 cycles after handshake edge; res_pass=1, pass_cnt=1, fail_cnt=0.
- All 8 {sel,a,b} combinations streamed back-to-back with a correct model → 8 res_valid pulses spaced SETTLE+2 cycles apart; pass_cnt=8, fail_cnt=0, any_fail=0.
- Faulty model with out2 forced 0, vectors 3'b110 then 3'b101 → both fail; fail_cnt=2, any_fail=1, first_fail_vec=3'b110, first_fail_got=2'b10 (not overwritten by second fail).
- CNT_W=2, 5 passing vectors → pass_cnt stays at 3 after the third; then stat_clr coincident with the sample of a failing vector → pass_cnt=0, fail_cnt=1, first_fail_* captured for that vector.
- Reset asserted for one cycle during SETTLE → no res_valid; counters, drv_* and any_fail=0; vec_ready=1 the next cycle. vec_valid held high during SETTLE causes no second accept until IDLE.
